// File: rtl/voice_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voice_dispatcher_pkg
//  Description : Shared types and default widths for the voice dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package voice_dispatcher_pkg;

   localparam int c_VOICE_COUNT    = 4;
   localparam int c_NOTE_WIDTH     = 7;
   localparam int c_VELOCITY_WIDTH = 7;

   typedef logic [c_NOTE_WIDTH-1:0]     note_t;
   typedef logic [c_VELOCITY_WIDTH-1:0] velocity_t;

   typedef struct packed {
      logic      active;
      note_t     note;
      velocity_t velocity;
   } voice_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      COMMIT = 2'd2
   } dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : voice_dispatcher_if
//  Description : Note-event handshake and voice-table outputs of the
//                voice dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface voice_dispatcher_if
   import voice_dispatcher_pkg::*;
#(
   parameter int VOICE_COUNT    = c_VOICE_COUNT,
   parameter int NOTE_WIDTH     = c_NOTE_WIDTH,
   parameter int VELOCITY_WIDTH = c_VELOCITY_WIDTH
);
   logic                                           event_valid;
   logic                                           event_ready;
   logic                                           event_on;
   logic [NOTE_WIDTH-1:0]                          event_note;
   logic [VELOCITY_WIDTH-1:0]                      event_velocity;
   logic [VOICE_COUNT-1:0]                         voice_active;
   logic [VOICE_COUNT-1:0][NOTE_WIDTH-1:0]         voice_note;
   logic [VOICE_COUNT-1:0][VELOCITY_WIDTH-1:0]     voice_velocity;
   logic [VOICE_COUNT-1:0]                         voice_trigger;
   logic [VOICE_COUNT-1:0]                         voice_release;
   logic                                           event_dropped;

   modport master (
      output event_valid, event_on, event_note, event_velocity,
      input  event_ready, voice_active, voice_note, voice_velocity,
             voice_trigger, voice_release, event_dropped
   );

   modport slave (
      input  event_valid, event_on, event_note, event_velocity,
      output event_ready, voice_active, voice_note, voice_velocity,
             voice_trigger, voice_release, event_dropped
   );
endinterface
`default_nettype wire

// File: rtl/voice_dispatcher_search.sv
`default_nettype none
// ============================================================================
//  Module      : voice_dispatcher_search
//  Description : Combinational associative search; reports whether any
//                element equals the needle and the lowest matching index.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_dispatcher_search #(
   parameter int ELEMENT_WIDTH = 8,
   parameter int ELEMENT_COUNT = 4,
   localparam int c_IDX_W      = $clog2(ELEMENT_COUNT)
) (
   input  wire logic [ELEMENT_COUNT-1:0][ELEMENT_WIDTH-1:0] i_elements,
   input  wire logic [ELEMENT_WIDTH-1:0]                    i_needle,
   output logic                                             o_found,
   output logic [c_IDX_W-1:0]                               o_index
);
   // Scan from the top down so the lowest matching index is the last written
   always_comb begin
      o_found = 1'b0;
      o_index = '0;
      for (int i = ELEMENT_COUNT - 1; i >= 0; i--) begin
         if (i_elements[i] == i_needle) begin
            o_found = 1'b1;
            o_index = c_IDX_W'(i);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/voice_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : voice_dispatcher
//  Description : Allocates MIDI note events to a pool of synth voices and
//                pulses per-voice trigger/release. Three-cycle
//                accept/search/commit sequence per event.
//                Optional macro VOICE_DISPATCHER_STEAL_EN: LRU voice stealing
//                when the pool is full (otherwise the event is dropped).
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_dispatcher
   import voice_dispatcher_pkg::*;
#(
   parameter int VOICE_COUNT    = c_VOICE_COUNT,
   parameter int NOTE_WIDTH     = c_NOTE_WIDTH,
   parameter int VELOCITY_WIDTH = c_VELOCITY_WIDTH
) (
   input wire logic           clock,
   input wire logic           reset,
   voice_dispatcher_if.slave  bus
);
   localparam int         c_IDX_W     = $clog2(VOICE_COUNT);
   localparam logic [1:0] c_ST_IDLE   = IDLE;
   localparam logic [1:0] c_ST_SEARCH = SEARCH;
   localparam logic [1:0] c_ST_COMMIT = COMMIT;

   logic [1:0]                                 r_state;
   logic                                       r_on;
   logic [NOTE_WIDTH-1:0]                      r_note;
   logic [VELOCITY_WIDTH-1:0]                  r_vel;
   logic [VOICE_COUNT-1:0]                     r_active;
   logic [VOICE_COUNT-1:0][NOTE_WIDTH-1:0]     r_note_tab;
   logic [VOICE_COUNT-1:0][VELOCITY_WIDTH-1:0] r_vel_tab;
   logic [VOICE_COUNT-1:0]                     r_trig;
   logic [VOICE_COUNT-1:0]                     r_rel;
   logic                                       r_drop;
   logic                                       r_hit;
   logic [c_IDX_W-1:0]                         r_hit_idx;
   logic                                       r_free;
   logic [c_IDX_W-1:0]                         r_free_idx;

   logic [VOICE_COUNT-1:0][NOTE_WIDTH:0]       w_keys;
   logic                                       w_hit;
   logic [c_IDX_W-1:0]                         w_hit_idx;
   logic                                       w_free;
   logic [c_IDX_W-1:0]                         w_free_idx;
   logic                                       w_accept;
   logic [c_IDX_W-1:0]                         w_tgt;
   logic [VOICE_COUNT-1:0]                     w_onehot;
   logic                                       w_alloc;
   logic                                       w_vel_wr;
   logic                                       w_clr;
   logic                                       w_trig;
   logic                                       w_rel;
   logic                                       w_drop;
   logic                                       w_touch;

   assign w_accept = (r_state == c_ST_IDLE) && bus.event_valid;
   assign w_onehot = {{(VOICE_COUNT-1){1'b0}}, 1'b1} << w_tgt;

   // Inactive slots carry a 0 in the key MSB so stale notes never match
   generate
      for (genvar i = 0; i < VOICE_COUNT; i++) begin : g_keys
         assign w_keys[i] = {r_active[i], r_note_tab[i]};
      end
   endgenerate

   voice_dispatcher_search #(
      .ELEMENT_WIDTH (NOTE_WIDTH + 1),
      .ELEMENT_COUNT (VOICE_COUNT)
   ) u_note_search (
      .i_elements (w_keys),
      .i_needle   ({1'b1, r_note}),
      .o_found    (w_hit),
      .o_index    (w_hit_idx)
   );

   voice_dispatcher_search #(
      .ELEMENT_WIDTH (1),
      .ELEMENT_COUNT (VOICE_COUNT)
   ) u_free_search (
      .i_elements (r_active),
      .i_needle   (1'b0),
      .o_found    (w_free),
      .o_index    (w_free_idx)
   );

`ifdef VOICE_DISPATCHER_STEAL_EN
   logic [VOICE_COUNT-1:0][c_IDX_W-1:0] r_age;
   logic [c_IDX_W-1:0]                  w_victim;

   // Victim is the least recently (re)started voice: the one with maximum age
   always_comb begin
      w_victim = '0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
         if (r_age[i] == c_IDX_W'(VOICE_COUNT - 1)) w_victim = c_IDX_W'(i);
      end
   end

   // LRU ages: touched voice becomes youngest, younger voices age by one
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < VOICE_COUNT; i++) r_age[i] <= c_IDX_W'(i);
      end else if (w_touch) begin
         for (int i = 0; i < VOICE_COUNT; i++) begin
            if (c_IDX_W'(i) == w_tgt)         r_age[i] <= '0;
            else if (r_age[i] < r_age[w_tgt]) r_age[i] <= r_age[i] + c_IDX_W'(1);
         end
      end
   end
`endif

   // Commit decision from the registered search results and latched event
   always_comb begin
      w_tgt    = '0;
      w_alloc  = 1'b0;
      w_vel_wr = 1'b0;
      w_clr    = 1'b0;
      w_trig   = 1'b0;
      w_rel    = 1'b0;
      w_drop   = 1'b0;
      w_touch  = 1'b0;
      if (r_state == c_ST_COMMIT) begin
         if (r_on) begin
            if (r_hit) begin
               w_tgt    = r_hit_idx;
               w_vel_wr = 1'b1;
               w_trig   = 1'b1;
               w_touch  = 1'b1;
            end else if (r_free) begin
               w_tgt    = r_free_idx;
               w_alloc  = 1'b1;
               w_trig   = 1'b1;
               w_touch  = 1'b1;
            end else begin
`ifdef VOICE_DISPATCHER_STEAL_EN
               w_tgt    = w_victim;
               w_alloc  = 1'b1;
               w_trig   = 1'b1;
               w_rel    = 1'b1;
               w_touch  = 1'b1;
`else
               w_drop   = 1'b1;
`endif
            end
         end else if (r_hit) begin
            w_tgt = r_hit_idx;
            w_clr = 1'b1;
            w_rel = 1'b1;
         end
      end
   end

   // Sequencer and event latch; velocity 0 note-on is folded into note-off
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
         r_on    <= 1'b0;
         r_note  <= '0;
         r_vel   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_state <= c_ST_SEARCH;
                  r_on    <= bus.event_on && (|bus.event_velocity);
                  r_note  <= bus.event_note;
                  r_vel   <= bus.event_velocity;
               end
            end
            c_ST_SEARCH: r_state <= c_ST_COMMIT;
            default:     r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Search results captured in the SEARCH cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hit      <= 1'b0;
         r_hit_idx  <= '0;
         r_free     <= 1'b0;
         r_free_idx <= '0;
      end else if (r_state == c_ST_SEARCH) begin
         r_hit      <= w_hit;
         r_hit_idx  <= w_hit_idx;
         r_free     <= w_free;
         r_free_idx <= w_free_idx;
      end
   end

   // Voice table and one-cycle output pulses updated at COMMIT
   always_ff @(posedge clock) begin
      if (reset) begin
         r_active   <= '0;
         r_note_tab <= '0;
         r_vel_tab  <= '0;
         r_trig     <= '0;
         r_rel      <= '0;
         r_drop     <= 1'b0;
      end else begin
         r_trig <= w_trig ? w_onehot : '0;
         r_rel  <= w_rel  ? w_onehot : '0;
         r_drop <= w_drop;
         if (w_alloc) begin
            r_active[w_tgt]   <= 1'b1;
            r_note_tab[w_tgt] <= r_note;
            r_vel_tab[w_tgt]  <= r_vel;
         end
         if (w_vel_wr) r_vel_tab[w_tgt] <= r_vel;
         if (w_clr)    r_active[w_tgt]  <= 1'b0;
      end
   end

   assign bus.event_ready    = (r_state == c_ST_IDLE) && !reset;
   assign bus.voice_active   = r_active;
   assign bus.voice_note     = r_note_tab;
   assign bus.voice_velocity = r_vel_tab;
   assign bus.voice_trigger  = r_trig;
   assign bus.voice_release  = r_rel;
   assign bus.event_dropped  = r_drop;

endmodule
`default_nettype wire
